// File: rtl/updown_counter.sv
// updown_counter: registered WIDTH-bit up/down counter with load, boundary decodes and wrap pulse.
// Define SATURATE_EN to hold at the limits instead of wrapping; wrap then flags each blocked step.
module updown_counter #(
    parameter int          WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap
);
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("updown_counter: WIDTH must be in 1..32");
    end else if (64'(RESET_VAL) >= (64'd1 << WIDTH)) begin : g_bad_reset
        $error("updown_counter: RESET_VAL must be below 2**WIDTH");
    end
    localparam logic [WIDTH-1:0] MAX = '1;
    logic [WIDTH-1:0] cnt_d, cnt_q, step;
    logic             wrap_d, wrap_q, boundary;
    always_comb begin
        boundary = en && (up ? cnt_q == MAX : cnt_q == '0);
        wrap_d   = !load && boundary;
        step     = up ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
`ifdef SATURATE_EN
        cnt_d    = load ? load_val : (en && !boundary) ? step : cnt_q;
`else
        cnt_d    = load ? load_val : en ? step : cnt_q;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= WIDTH'(RESET_VAL);
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end
    assign cnt    = cnt_q;
    assign wrap   = wrap_q;
    assign at_max = cnt_q == MAX;
    assign at_min = cnt_q == '0;
endmodule
